config_field_ctrl: RTL and testbench
====================================

Name: config_field_ctrl

Overview:
Consumes the single-cycle pulses from the button conditioning stage (config, up, down) and runs the time/date configuration sequence for the RTC.
On entry to configuration mode it snapshots the current RTC time into shadow registers and lets the user edit one BCD field at a time. It writes each edited field to the RTC bus controller through a req/ack handshake, then advances to the next field.
It sits between the push-button conditioners and the RTC write controller.

Parameters:
ACK_TIMEOUT, 1000, cycles to wait for wr_ack before aborting the write.
TW, 10, width of the timeout counter; must satisfy 2^TW > ACK_TIMEOUT.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
push_cfg  in  1  one-cycle pulse: enter config, or commit the current field.
push_up  in  1  one-cycle pulse: increment the current field.
push_down  in  1  one-cycle pulse: decrement the current field.
rtc_now  in  48  live RTC value, BCD, {year,month,day,hour,min,sec}, 8 bits each.
wr_ack  in  1  write accepted by the RTC controller; level, sampled only in WAIT.
cfg_mode  out  1  high while the block is outside IDLE.
field_sel  out  3  current field index, 0..5.
field_val  out  8  BCD value of the current field (for display).
wr_req  out  1  write request, held until ack or timeout.
wr_addr  out  8  RTC register address of the field being written.
wr_data  out  8  BCD data for the field being written.
err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, field_sel=0, all shadow registers=0, timeout counter=0.
  - cfg_mode=0, wr_req=0, wr_addr=0, wr_data=0, err=0.
- Fields (index, name, BCD range, address):
  - 0 seconds, 00-59, 0x21.
  - 1 minutes, 00-59, 0x22.
  - 2 hours, 00-23, 0x23.
  - 3 day, 01-31, 0x24.
  - 4 month, 01-12, 0x25.
  - 5 year, 00-99, 0x26.
- States:
  - IDLE: on push_cfg, next cycle state=EDIT, cfg_mode=1, field_sel=0, and all six shadows load from rtc_now. Up/down pulses are ignored.
  - EDIT: field_val = shadow[field_sel].
    - push_up: shadow steps +1 in BCD, wrapping max->min; visible on field_val next cycle.
    - push_down: shadow steps -1 in BCD, wrapping min->max.
    - push_up and push_down in the same cycle: both ignored.
    - push_cfg: next cycle state=WAIT, wr_req=1, wr_addr=ADDR[field_sel], wr_data=shadow[field_sel], counter cleared. push_cfg takes priority over a simultaneous up/down, which is dropped.
  - WAIT: wr_req, wr_addr and wr_data are held stable; all push inputs are ignored.
    - wr_ack=1: next cycle wr_req=0. If field_sel<5, then field_sel+1 and state=EDIT; if field_sel=5, then state=IDLE and field_sel=0.
    - Counter reaches ACK_TIMEOUT-1 with no ack: next cycle wr_req=0, err=1 for one cycle, state=IDLE, field_sel=0. Shadows are retained but reloaded on the next entry.
    - wr_ack on the same cycle as the timeout terminal count: ack wins.
- BCD arithmetic:
  - Units digit 9->0 carries into tens; stepping down from units 0 borrows.
  - Wrap is decided on the full value: for example, 23 +1 -> 00 for hours, and 01 -1 -> 12 for month.
  - Day range is fixed at 01-31, with no month/leap validation.
  - Shadow values are always legal BCD after any operation.
  - An rtc_now value loaded with illegal BCD is passed through unchanged until edited. The first up/down on it yields the field minimum.
- Latency: push_cfg to wr_req is 1 cycle; wr_ack to wr_req low is 1 cycle.
- wr_ack asserted in IDLE or EDIT is ignored.
- rst_n asserted mid-write drops wr_req immediately (asynchronously).

Decomposition:
- Package cfg_pkg holds:
  - the state encoding (IDLE, EDIT, WAIT);
  - the field indices;
  - the field address constants 0x21-0x26;
  - per-field BCD MIN/MAX constants.
- Sub-module bcd_step (combinational) handles the arithmetic:
  - inputs: value[7:0], up, down, min[7:0], max[7:0];
  - output: next value with carry/borrow and wrap.
  - One instance serves the selected field.

Test Plan:
1. rtc_now=0x99_12_31_23_59_58, push_cfg -> next cycle cfg_mode=1, field_sel=0, field_val=0x58. Then push_up x2 -> 0x59, then 0x00.
2. In EDIT on field 2 (hours=0x00), push_down -> 0x23. Select month=0x01, push_down -> 0x12. Units carry: minutes 0x09 +1 -> 0x10.
3. Commit field 0 with push_cfg -> wr_req=1, wr_addr=0x21, wr_data=shadow. Hold wr_ack=0 for 5 cycles -> outputs stable. wr_ack=1 -> wr_req=0 next cycle, field_sel=1.
4. Commit all six fields with ack -> addresses 0x21..0x26 issued in order. After the last ack, cfg_mode=0 and field_sel=0.
5. ACK_TIMEOUT=8, never ack -> wr_req drops after 8 cycles, err pulses for exactly 1 cycle, state=IDLE.
6. Simultaneous events:
   - push_up+push_down together -> value unchanged;
   - push_cfg+push_up together -> write of the unincremented value;
   - rst_n low during WAIT -> wr_req=0 with no clock edge.

Source files
------------

// File: rtl/config_field_ctrl_pkg.sv
// Shared types and constants for the RTC time/date configuration controller:
// state encoding, field indices, RTC register addresses and BCD limits.
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] FLD_SEC   = 3'd0;
    localparam logic [2:0] FLD_MIN   = 3'd1;
    localparam logic [2:0] FLD_HOUR  = 3'd2;
    localparam logic [2:0] FLD_DAY   = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_YEAR  = 3'd5;

    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;

    localparam logic [7:0] MIN_SEC   = 8'h00, MAX_SEC   = 8'h59;
    localparam logic [7:0] MIN_MIN   = 8'h00, MAX_MIN   = 8'h59;
    localparam logic [7:0] MIN_HOUR  = 8'h00, MAX_HOUR  = 8'h23;
    localparam logic [7:0] MIN_DAY   = 8'h01, MAX_DAY   = 8'h31;
    localparam logic [7:0] MIN_MONTH = 8'h01, MAX_MONTH = 8'h12;
    localparam logic [7:0] MIN_YEAR  = 8'h00, MAX_YEAR  = 8'h99;

    function automatic logic [7:0] field_addr(input logic [2:0] idx);
        case (idx)
            FLD_SEC:   return ADDR_SEC;
            FLD_MIN:   return ADDR_MIN;
            FLD_HOUR:  return ADDR_HOUR;
            FLD_DAY:   return ADDR_DAY;
            FLD_MONTH: return ADDR_MONTH;
            default:   return ADDR_YEAR;
        endcase
    endfunction

    function automatic logic [7:0] field_min(input logic [2:0] idx);
        case (idx)
            FLD_SEC:   return MIN_SEC;
            FLD_MIN:   return MIN_MIN;
            FLD_HOUR:  return MIN_HOUR;
            FLD_DAY:   return MIN_DAY;
            FLD_MONTH: return MIN_MONTH;
            default:   return MIN_YEAR;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [2:0] idx);
        case (idx)
            FLD_SEC:   return MAX_SEC;
            FLD_MIN:   return MAX_MIN;
            FLD_HOUR:  return MAX_HOUR;
            FLD_DAY:   return MAX_DAY;
            FLD_MONTH: return MAX_MONTH;
            default:   return MAX_YEAR;
        endcase
    endfunction

endpackage

// File: rtl/config_field_ctrl_bcd_step.sv
// Combinational single-step BCD increment/decrement with wrap inside [min, max].
module bcd_step (
    input  logic [7:0] value,
    input  logic       up,
    input  logic       down,
    input  logic [7:0] min,
    input  logic [7:0] max,
    output logic [7:0] next_value
);

    logic legal;

    // Byte comparison matches numeric order only once both digits are <= 9.
    assign legal = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
                   (value >= min) && (value <= max);

    always_comb begin
        next_value = value;
        if (up ^ down) begin
            if (!legal) begin
                next_value = min;
            end else if (up) begin
                if (value == max)
                    next_value = min;
                else if (value[3:0] == 4'd9)
                    next_value = {value[7:4] + 4'd1, 4'd0};
                else
                    next_value = value + 8'd1;
            end else begin
                if (value == min)
                    next_value = max;
                else if (value[3:0] == 4'd0)
                    next_value = {value[7:4] - 4'd1, 4'd9};
                else
                    next_value = value - 8'd1;
            end
        end
    end

endmodule

// File: rtl/config_field_ctrl.sv
// RTC time/date configuration sequencer: snapshot, per-field BCD edit,
// and req/ack write of each field to the RTC bus controller.
module config_field_ctrl
    import cfg_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000,
    parameter int TW          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_cfg,
    input  logic        push_up,
    input  logic        push_down,
    input  logic [47:0] rtc_now,
    input  logic        wr_ack,
    output logic        cfg_mode,
    output logic [2:0]  field_sel,
    output logic [7:0]  field_val,
    output logic        wr_req,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        err
);

    state_t               state_reg, state_next;
    logic [2:0]           field_sel_reg, field_sel_next;
    logic [TW-1:0]        cnt_reg, cnt_next;
    logic                 wr_req_reg, wr_req_next;
    logic [7:0]           wr_addr_reg, wr_addr_next;
    logic [7:0]           wr_data_reg, wr_data_next;
    logic                 err_reg, err_next;
    logic                 load_shadow, edit_shadow, timeout;
    logic [8*NUM_FIELDS-1:0] shadow_flat;
    logic [7:0]           sel_val, step_val;

    assign timeout = (cnt_reg == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_FIELDS; i++)
            if (field_sel_reg == 3'(i))
                sel_val = shadow_flat[i*8 +: 8];
    end

    bcd_step u_bcd_step (
        .value      (sel_val),
        .up         (push_up),
        .down       (push_down),
        .min        (field_min(field_sel_reg)),
        .max        (field_max(field_sel_reg)),
        .next_value (step_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (push_cfg) state_next = ST_EDIT;
            ST_EDIT: if (push_cfg) state_next = ST_WAIT;
            ST_WAIT: begin
                if (wr_ack)
                    state_next = (field_sel_reg == FLD_YEAR) ? ST_IDLE : ST_EDIT;
                else if (timeout)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        field_sel_next = field_sel_reg;
        cnt_next       = cnt_reg;
        wr_req_next    = wr_req_reg;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        err_next       = 1'b0;
        load_shadow    = 1'b0;
        edit_shadow    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (push_cfg) begin
                    field_sel_next = FLD_SEC;
                    load_shadow    = 1'b1;
                end
            end
            ST_EDIT: begin
                // A commit drops any up/down arriving in the same cycle.
                if (push_cfg) begin
                    wr_req_next  = 1'b1;
                    wr_addr_next = field_addr(field_sel_reg);
                    wr_data_next = sel_val;
                    cnt_next     = '0;
                end else begin
                    edit_shadow = push_up ^ push_down;
                end
            end
            ST_WAIT: begin
                if (wr_ack) begin
                    wr_req_next    = 1'b0;
                    field_sel_next = (field_sel_reg == FLD_YEAR) ? FLD_SEC
                                                                 : field_sel_reg + 3'd1;
                end else if (timeout) begin
                    wr_req_next    = 1'b0;
                    err_next       = 1'b1;
                    field_sel_next = FLD_SEC;
                end else begin
                    cnt_next = cnt_reg + TW'(1);
                end
            end
            default: begin
                wr_req_next    = 1'b0;
                field_sel_next = FLD_SEC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_sel_reg <= '0;
            cnt_reg       <= '0;
            wr_req_reg    <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            field_sel_reg <= field_sel_next;
            cnt_reg       <= cnt_next;
            wr_req_reg    <= wr_req_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            err_reg       <= err_next;
        end
    end

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_shadow
        logic [7:0] shadow_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                shadow_reg <= '0;
            else if (load_shadow)
                shadow_reg <= rtc_now[gi*8 +: 8];
            else if (edit_shadow && field_sel_reg == 3'(gi))
                shadow_reg <= step_val;
        end
        assign shadow_flat[gi*8 +: 8] = shadow_reg;
    end

    assign cfg_mode  = (state_reg != ST_IDLE);
    assign field_sel = field_sel_reg;
    assign field_val = sel_val;
    assign wr_req    = wr_req_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_config_field_ctrl.sv
// Bench for config_field_ctrl: directed steps plus random pushes, checked
// against a decimal-arithmetic reference model of the configuration sequence.
module tb_config_field_ctrl;

    localparam int T_OUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_cfg = 1'b0, push_up = 1'b0, push_down = 1'b0, wr_ack = 1'b0;
    logic [47:0] rtc_now = '0;
    logic        cfg_mode, wr_req, err;
    logic [2:0]  field_sel;
    logic [7:0]  field_val, wr_addr, wr_data;

    config_field_ctrl #(.ACK_TIMEOUT(T_OUT), .TW(10)) dut (
        .clk(clk), .rst_n(rst_n), .push_cfg(push_cfg), .push_up(push_up),
        .push_down(push_down), .rtc_now(rtc_now), .wr_ack(wr_ack),
        .cfg_mode(cfg_mode), .field_sel(field_sel), .field_val(field_val),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0=idle, 1=editing, 2=awaiting write ack.
    int         m_mode;
    int         m_sel;
    logic [7:0] m_sh [6];
    logic       m_req, m_err;
    logic [7:0] m_addr, m_data;
    int         m_cnt;
    int lo_tab [6] = '{0, 0, 0, 1, 1, 0};
    int hi_tab [6] = '{59, 59, 23, 31, 12, 99};

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [7:0] m_step(input logic [7:0] v, input bit up, input int idx);
        int t, u, n;
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        if (t > 9 || u > 9) return to_bcd(lo_tab[idx]);
        n = t * 10 + u;
        if (n < lo_tab[idx] || n > hi_tab[idx]) return to_bcd(lo_tab[idx]);
        if (up) n = (n == hi_tab[idx]) ? lo_tab[idx] : n + 1;
        else    n = (n == lo_tab[idx]) ? hi_tab[idx] : n - 1;
        return to_bcd(n);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_sel = 0; m_req = 0; m_err = 0;
        m_addr = '0; m_data = '0; m_cnt = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = '0;
    endtask

    task automatic m_clock(input bit c, input bit u, input bit d, input bit a);
        m_err = 0;
        case (m_mode)
            0: if (c) begin
                m_mode = 1; m_sel = 0;
                for (int i = 0; i < 6; i++) m_sh[i] = rtc_now[i*8 +: 8];
            end
            1: if (c) begin
                m_mode = 2; m_req = 1; m_cnt = 0;
                m_addr = 8'h21 + 8'(m_sel); m_data = m_sh[m_sel];
            end else if (u != d) begin
                m_sh[m_sel] = m_step(m_sh[m_sel], u, m_sel);
            end
            default: if (a) begin
                m_req = 0;
                if (m_sel < 5) begin m_sel++; m_mode = 1; end
                else begin m_sel = 0; m_mode = 0; end
            end else if (m_cnt == T_OUT - 1) begin
                m_req = 0; m_err = 1; m_mode = 0; m_sel = 0;
            end else begin
                m_cnt++;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cfg_mode"},  8'(cfg_mode),  8'(m_mode != 0));
        chk({tag, ".field_sel"}, 8'(field_sel), 8'(m_sel));
        chk({tag, ".field_val"}, field_val,     m_sh[m_sel]);
        chk({tag, ".wr_req"},    8'(wr_req),    8'(m_req));
        chk({tag, ".wr_addr"},   wr_addr,       m_addr);
        chk({tag, ".wr_data"},   wr_data,       m_data);
        chk({tag, ".err"},       8'(err),       8'(m_err));
    endtask

    // Drive one cycle of inputs, clock, then compare DUT against the model.
    task automatic cycle(input string tag, input bit c, input bit u, input bit d, input bit a);
        push_cfg = c; push_up = u; push_down = d; wr_ack = a;
        @(posedge clk);
        m_clock(c, u, d, a);
        #1;
        push_cfg = 0; push_up = 0; push_down = 0; wr_ack = 0;
        check_all(tag);
    endtask

    int req_cycles, err_cycles;
    logic [7:0] held;

    initial begin
        m_reset();
        #2;
        check_all("reset");
        #10;
        rst_n = 1'b1;

        // Snapshot and seconds wrap 58 -> 59 -> 00.
        rtc_now = 48'h99_12_31_23_59_58;
        cycle("enter", 1, 0, 0, 0);
        chk("enter.val58", field_val, 8'h58);
        cycle("up1", 0, 1, 0, 0);
        chk("up1.val59", field_val, 8'h59);
        cycle("up2", 0, 1, 0, 0);
        chk("up2.wrap00", field_val, 8'h00);

        // Commit seconds, stall the ack with ignored pushes, then ack.
        cycle("commit0", 1, 0, 0, 0);
        chk("commit0.addr", wr_addr, 8'h21);
        for (int i = 0; i < 5; i++) cycle("stall", 0, (i % 2) == 0, (i % 2) == 1, 0);
        cycle("ack0", 0, 0, 0, 1);
        chk("ack0.sel1", 8'(field_sel), 8'd1);
        for (int f = 1; f < 6; f++) begin
            cycle("commit", 1, 0, 0, 0);
            cycle("ack", 0, 0, 0, 1);
        end
        chk("sess1.cfg_mode0", 8'(cfg_mode), 8'd0);

        // Second session: carries, borrows and wraps, addresses in order.
        rtc_now = 48'h99_01_31_00_09_58;
        cycle("enter2", 1, 0, 0, 0);
        for (int f = 0; f < 6; f++) begin
            if (f == 1) begin cycle("min_up", 0, 1, 0, 0);  chk("min.carry10", field_val, 8'h10); end
            if (f == 2) begin cycle("hr_down", 0, 0, 1, 0); chk("hr.wrap23", field_val, 8'h23); end
            if (f == 4) begin cycle("mo_down", 0, 0, 1, 0); chk("mo.wrap12", field_val, 8'h12); end
            cycle("commit", 1, 0, 0, 0);
            chk("seq.addr", wr_addr, 8'h21 + 8'(f));
            cycle("ack", 0, 0, 0, 1);
        end
        chk("sess2.cfg_mode0", 8'(cfg_mode), 8'd0);
        chk("sess2.sel0", 8'(field_sel), 8'd0);

        // Timeout: request lasts exactly T_OUT cycles, err pulses once.
        cycle("enter3", 1, 0, 0, 0);
        cycle("commit3", 1, 0, 0, 0);
        req_cycles = 0; err_cycles = 0;
        if (wr_req) req_cycles++;
        for (int i = 0; i < T_OUT + 3; i++) begin
            cycle("to", 0, 0, 0, 0);
            if (wr_req) req_cycles++;
            if (err) err_cycles++;
        end
        chk("to.req_cycles", 8'(req_cycles), 8'(T_OUT));
        chk("to.err_cycles", 8'(err_cycles), 8'd1);
        chk("to.idle", 8'(cfg_mode), 8'd0);

        // Simultaneous pushes, illegal BCD snapshot, then reset during a write.
        rtc_now = 48'h45_12_31_45_30_7F;
        cycle("enter4", 1, 0, 0, 0);
        chk("illegal.pass", field_val, 8'h7F);
        cycle("ill_up", 0, 1, 0, 0);
        chk("illegal.min", field_val, 8'h00);
        cycle("updown", 0, 1, 1, 0);
        chk("updown.same", field_val, 8'h00);
        held = field_val;
        cycle("cfg_up", 1, 1, 0, 0);
        chk("cfg_up.data", wr_data, held);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("async.req0", 8'(wr_req), 8'd0);
        check_all("async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Random traffic, including random (often illegal) snapshots.
        for (int i = 0; i < 500; i++) begin
            rtc_now = {16'($urandom), 32'($urandom)};
            cycle("rand", $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
